csram_update_sequencer: RTL
===========================

Name: csram_update_sequencer

Overview:
Per-tick controller that walks every neuron entry of the core's configuration/state SRAM. For each entry it reads the word, hands it to the neuron block over a valid/ready handshake, and collects the updated membrane potential. It then writes the word back with only the potential field replaced. It sits between the core controller (tick source) and the SRAM port, directly driving the SRAM's clk-domain wen/address/data_in and consuming its data_out.

Parameters:
NUM_NEURONS, 256, number of SRAM entries walked per tick
WIDTH, 367, SRAM word width
WRITE_INDEX, 102, LSB position of the potential field inside the word
WRITE_WIDTH, 9, potential field width

Ports:
clk  in  1  core clock; SRAM samples on negedge of the same clock
rst  in  1  synchronous, active-low reset
tick  in  1  single-cycle start pulse for one full neuron sweep
busy  out  1  high from tick acceptance until the done cycle inclusive
done  out  1  one-cycle pulse after the last entry's write-back
tick_overrun  out  1  sticky; set when tick arrives while busy
csram_wen  out  1  SRAM write enable
csram_address  out  $clog2(NUM_NEURONS)  SRAM address
csram_data_in  out  WIDTH  SRAM write data
csram_data_out  in  WIDTH  SRAM read data
param_data  out  WIDTH  neuron word presented to the neuron block
param_valid  out  1  param_data valid
param_ready  in  1  neuron block accepts param_data
result_potential  in  WRITE_WIDTH  updated potential
result_valid  in  1  result_potential valid

Behaviour:
- All outputs are registered. Reset values: busy=0, done=0, tick_overrun=0, csram_wen=0, csram_address=0, csram_data_in=0, param_data=0, param_valid=0.
- FSM states: IDLE, READ, CAPTURE, PRESENT, WAIT_RES, WRITE, ADVANCE, DONE.
- IDLE: on tick=1, go to READ with index=0 and busy=1.
- READ: csram_address=index, csram_wen=0. The SRAM updates data_out on the negedge inside this cycle. Go to CAPTURE.
- CAPTURE: latch csram_data_out into the word register and param_data. Set param_valid=1. Go to PRESENT.
- PRESENT: hold param_data and param_valid until the cycle with param_ready=1. param_valid drops the cycle after. Go to WAIT_RES. result_valid is ignored in PRESENT.
- WAIT_RES: on result_valid=1, latch result_potential. Go to WRITE.
- WRITE: drive for exactly one cycle csram_wen=1, csram_address=index, and csram_data_in = word with bits [WRITE_INDEX +: WRITE_WIDTH] replaced by the latched potential. All other bits are unchanged. Go to ADVANCE.
- ADVANCE: csram_wen=0. If index==NUM_NEURONS-1, go to DONE. Otherwise index+1 and go to READ.
- DONE: done=1 for one cycle; busy stays 1 in this cycle. Then IDLE with busy=0.
- Minimum cost per neuron with zero-wait handshakes: 5 cycles (READ, CAPTURE, PRESENT, WAIT_RES, WRITE), plus ADVANCE. Sweep latency is 6*NUM_NEURONS+1 cycles from tick to done.
- csram_wen is only ever 1 in WRITE. The SRAM never sees a read and a write of the same address in one cycle.
- A tick while busy (including the DONE cycle) is ignored and sets tick_overrun. Only rst clears it.
- Potential is written verbatim: no saturation here, and no width conversion beyond WRITE_WIDTH.
- rst=0 in any state: next edge returns to IDLE with all reset values. csram_wen drops at that edge, so a write in progress is cut off and the entry is left as last written.
- The index wraps only via reset or a new tick. It never increments past NUM_NEURONS-1.

Optional Feature:
CSRAM_WB_SKIP_EN
- Defined: in WAIT_RES, if result_potential equals the stored potential field, skip WRITE and go straight to ADVANCE. csram_wen stays 0 for that entry.
- Undefined: WRITE occurs for every entry unconditionally.

Decomposition:
- Shared package csram_pkg holds:
  - FSM state enum
  - default NUM_NEURONS/WIDTH/WRITE_INDEX/WRITE_WIDTH constants
  - ADDR_W = $clog2(NUM_NEURONS)
- One natural sub-module: csram_field_merge. It is combinational: word, potential -> merged word, parameterised by WRITE_INDEX/WRITE_WIDTH, and is reused by the loader and debug paths.

Test Plan:
1. NUM_NEURONS=4, param_ready and result_valid tied 1, result_potential=index+1. Required: done 25 cycles after tick, and each entry's bits [110:102] equal index+1 with all other bits unchanged.
2. param_ready held 0 for 3 cycles on entry 2. Required: param_data/param_valid are stable throughout, and no csram_wen=1 occurs until the handshake completes.
3. Second tick 10 cycles after the first. Required: tick_overrun=1, sweep completes normally, and exactly one done pulse.
4. rst=0 asserted in WRITE of entry 1. Required: csram_wen=0 at the next edge, all outputs at reset values, and entries 2-3 untouched.
5. Word all-ones, result_potential=9'h000. Required: written word equals all-ones except bits [110:102]=0. Check the boundary at the field MSB/LSB.
6. With CSRAM_WB_SKIP_EN, result equals the stored potential for entry 0. Required: no csram_wen for entry 0, and done arrives 1 cycle earlier than without the macro.

Source files
------------

// File: rtl/csram_pkg.sv
// rtl/csram_pkg.sv - shared state encoding and default geometry for the CSRAM update sequencer
// Imported by csram_update_sequencer and csram_field_merge.
package csram_pkg;

  localparam int NUM_NEURONS_DEF = 256;
  localparam int WIDTH_DEF       = 367;
  localparam int WRITE_INDEX_DEF = 102;
  localparam int WRITE_WIDTH_DEF = 9;
  localparam int ADDR_W          = $clog2(NUM_NEURONS_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_PRESENT,
    S_WAIT_RES,
    S_WRITE,
    S_ADVANCE,
    S_DONE
  } state_t;

endpackage

// File: rtl/csram_field_merge.sv
// rtl/csram_field_merge.sv - replaces the potential field of a neuron word, leaving every other bit intact
// Purely combinational; shared with the loader and debug paths.
module csram_field_merge
  import csram_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int WRITE_INDEX = WRITE_INDEX_DEF,
  parameter int WRITE_WIDTH = WRITE_WIDTH_DEF
) (
  input  logic [WIDTH-1:0]       i_word,
  input  logic [WRITE_WIDTH-1:0] i_potential,
  output logic [WIDTH-1:0]       o_word
);

  always_comb begin
    o_word = i_word;
    o_word[WRITE_INDEX +: WRITE_WIDTH] = i_potential;
  end

endmodule

// File: rtl/csram_update_sequencer.sv
// rtl/csram_update_sequencer.sv - per-tick read/present/write-back sweep over the neuron SRAM
// Build option CSRAM_WB_SKIP_EN: skip the write-back when the new potential equals the stored one.
module csram_update_sequencer
  import csram_pkg::*;
#(
  parameter  int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter  int WIDTH       = WIDTH_DEF,
  parameter  int WRITE_INDEX = WRITE_INDEX_DEF,
  parameter  int WRITE_WIDTH = WRITE_WIDTH_DEF,
  localparam int AW          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  output logic                   busy,
  output logic                   done,
  output logic                   tick_overrun,
  output logic                   csram_wen,
  output logic [AW-1:0]          csram_address,
  output logic [WIDTH-1:0]       csram_data_in,
  input  logic [WIDTH-1:0]       csram_data_out,
  output logic [WIDTH-1:0]       param_data,
  output logic                   param_valid,
  input  logic                   param_ready,
  input  logic [WRITE_WIDTH-1:0] result_potential,
  input  logic                   result_valid
);

  localparam logic [AW-1:0] LAST_INDEX = AW'(NUM_NEURONS - 1);

  state_t           r_state;
  logic [AW-1:0]    r_index;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_data_in;
  logic [WIDTH-1:0] r_param_data;
  logic             r_param_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_overrun;
  logic             r_wen;
  logic [WIDTH-1:0] w_merged;
  logic             w_skip;

  csram_field_merge #(
    .WIDTH       (WIDTH),
    .WRITE_INDEX (WRITE_INDEX),
    .WRITE_WIDTH (WRITE_WIDTH)
  ) u_merge (
    .i_word      (r_word),
    .i_potential (result_potential),
    .o_word      (w_merged)
  );

`ifdef CSRAM_WB_SKIP_EN
  assign w_skip = (result_potential == r_word[WRITE_INDEX +: WRITE_WIDTH]);
`else
  assign w_skip = 1'b0;
`endif

  // The merged word is registered on leaving WAIT_RES so it is already on the bus for the whole WRITE cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_index       <= '0;
      r_word        <= '0;
      r_data_in     <= '0;
      r_param_data  <= '0;
      r_param_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_overrun     <= 1'b0;
      r_wen         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wen  <= 1'b0;
      if (tick && r_busy) r_overrun <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (tick) begin
            r_index <= '0;
            r_busy  <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_word        <= csram_data_out;
          r_param_data  <= csram_data_out;
          r_param_valid <= 1'b1;
          r_state       <= S_PRESENT;
        end
        S_PRESENT: begin
          if (param_ready) begin
            r_param_valid <= 1'b0;
            r_state       <= S_WAIT_RES;
          end
        end
        S_WAIT_RES: begin
          if (result_valid) begin
            if (w_skip) begin
              r_state <= S_ADVANCE;
            end else begin
              r_wen     <= 1'b1;
              r_data_in <= w_merged;
              r_state   <= S_WRITE;
            end
          end
        end
        S_WRITE: r_state <= S_ADVANCE;
        S_ADVANCE: begin
          if (r_index == LAST_INDEX) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_index <= r_index + 1'b1;
            r_state <= S_READ;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign tick_overrun  = r_overrun;
  assign csram_wen     = r_wen;
  assign csram_address = r_index;
  assign csram_data_in = r_data_in;
  assign param_data    = r_param_data;
  assign param_valid   = r_param_valid;

endmodule
